pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Drives the write-enable and flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three sources: load-use hazards, taken branches resolved in MEM, and a variable-latency data-memory handshake.
- Keeps a small wait-state FSM with a timeout.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
MAX_WAIT, 15, maximum consecutive MEM_WAIT cycles before forced release (1..255)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
reset  input  1  synchronous active-low reset (0 = reset), sampled on the clk rising edge
id_rs1  input  5  rs1 of the instruction in ID
id_rs2  input  5  rs2 of the instruction in ID
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  rd of the instruction in EX
ex_memread  input  1  EX instruction is a load
mem_branch  input  1  MEM instruction is a branch
mem_zero  input  1  ALU zero flag in MEM
mem_access  input  1  MEM instruction reads or writes data memory
dmem_ready  input  1  data memory completes the access this cycle
dmem_req  output  1  data memory access request
pc_write  output  1  PC load enable
pc_src  output  1  1 = PC loads the branch target (PCSum in MEM)
if_id_write  output  1  IF_ID load enable
if_id_flush  output  1  IF_ID synchronous clear
id_ex_flush  output  1  ID_EX clear (bubble insert)
ex_mem_write  output  1  EX_MEM load enable
ex_mem_flush  output  1  EX_MEM clear
mem_wb_write  output  1  MEM_WB load enable
err_timeout  output  1  sticky: a memory access was force-released
stall_cnt  output  CNT_W  cycles with pc_write=0, saturating
flush_cnt  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Control outputs are combinational from state and inputs. state, wait_cnt, err_timeout and the counters are registered.
- While reset=0, outputs are forced:
  - pc_write, if_id_write, ex_mem_write, mem_wb_write, pc_src, dmem_req = 0
  - if_id_flush, id_ex_flush, ex_mem_flush = 1
  - state=RUN, wait_cnt=0, err_timeout=0, stall_cnt=0, flush_cnt=0
  - Reset during MEM_WAIT abandons the access; dmem_req drops the same cycle.
- dmem_req = mem_access in both states.
- FSM states: RUN, MEM_WAIT.
- Freeze cycle: all write enables and flushes are 0, pc_src=0, so every pipeline register holds. Freeze occurs when:
  - RUN with mem_access=1 and dmem_ready=0 → next state MEM_WAIT, wait_cnt<=1.
  - MEM_WAIT with dmem_ready=0 and wait_cnt<MAX_WAIT → stay, wait_cnt+1.
- Release cycle: MEM_WAIT with dmem_ready=1, or wait_cnt==MAX_WAIT.
  - Evaluated as a normal RUN cycle; next state RUN, wait_cnt<=0.
  - Forced release (dmem_ready still 0) sets err_timeout=1. It is cleared only by reset.
- Normal cycle (RUN without freeze, or release). Defaults: all write enables 1, flushes 0, pc_src 0.
  - Taken branch (mem_branch & mem_zero):
    - pc_src=1, pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1
    - flush_cnt+1
  - Load-use (ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))):
    - pc_write=0, if_id_write=0, id_ex_flush=1; EX_MEM and MEM_WB advance.
    - Exactly one bubble per hazard.
  - Priority: freeze > taken branch > load-use. A taken branch suppresses a simultaneous load-use stall because the ID instruction is discarded.
  - x0 never causes a stall.
- stall_cnt increments on every non-reset cycle with pc_write=0 (freeze or load-use). Both counters saturate at 2^CNT_W-1.
- Latency: a taken branch redirects the PC on the same edge that flushes; penalty is 3 cycles. A memory access with k wait cycles stalls the pipe k cycles.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs → flushes=1, enables=0, counters=0, err_timeout=0; the first cycle after release with no hazards has all enables=1.
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for 1 cycle → pc_write=0, if_id_write=0, id_ex_flush=1, stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Branch plus load-use together: mem_branch=1, mem_zero=1, load-use also true → pc_src=1, pc_write=1, the three flushes=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_access=1, dmem_ready low 3 cycles then high → 3 freeze cycles with dmem_req=1 and all enables 0, release on cycle 4, stall_cnt=3, err_timeout=0.
- Timeout: MAX_WAIT=4, dmem_ready stuck 0 → freeze cycles are the RUN entry cycle plus 3 MEM_WAIT cycles, release on the 5th cycle (wait_cnt==4), err_timeout=1 and stays 1 until reset.
- Saturation: CNT_W=4, 20 consecutive load-use stalls → stall_cnt=15. Reset mid-MEM_WAIT → state RUN, dmem_req=0 the same cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage RISC-V pipeline.
// Generates pipeline register enables and flushes from three sources:
//   - load-use hazards
//   - taken branches resolved in MEM
//   - a variable-latency data-memory handshake (wait FSM with timeout)
// Also keeps saturating stall and flush cycle counters.
module pipeline_hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_write,
   output logic             pc_src,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_write,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              err_timeout_reg, err_timeout_next;

   logic freeze;
   logic taken_branch;
   logic load_use;
   logic [1:0] cnt_inc;

   // Freeze: the memory access has not completed and the wait budget is not yet spent.
   // In MEM_WAIT, reaching the budget (or dmem_ready) turns this into a release cycle.
   assign freeze = (state_reg == RUN) ? (mem_access & ~dmem_ready)
                                      : (~dmem_ready & (wait_cnt_reg < WAIT_LIMIT));

   assign taken_branch = mem_branch & mem_zero;

   // x0 is hard-wired, so a load targeting it never creates a real dependency
   assign load_use = ex_memread & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

   // State register: FSM state, wait counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= RUN;
         wait_cnt_reg    <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wait_cnt_reg    <= wait_cnt_next;
         err_timeout_reg <= err_timeout_next;
      end
   end

   // Next-state logic: enter MEM_WAIT on a stalled access, leave on ready or timeout
   always_comb begin
      state_next       = state_reg;
      wait_cnt_next    = wait_cnt_reg;
      err_timeout_next = err_timeout_reg;
      case (state_reg)
         RUN: begin
            if (freeze) begin
               state_next    = MEM_WAIT;
               wait_cnt_next = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (freeze) begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end else begin
               state_next    = RUN;
               wait_cnt_next = '0;
               // Release without dmem_ready means the access was abandoned
               if (!dmem_ready) begin
                  err_timeout_next = 1'b1;
               end
            end
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // Output logic: reset forcing, then freeze > taken branch > load-use
   always_comb begin
      dmem_req     = reset & mem_access;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_write = 1'b0;
      if (!reset) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (!freeze) begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         ex_mem_write = 1'b1;
         mem_wb_write = 1'b1;
         if (taken_branch) begin
            // The wrong-path instructions in IF, ID and EX are discarded, which
            // also cancels any load-use stall on the ID instruction.
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
         end
      end
   end

   // Counter 0 counts stalled PC cycles, counter 1 counts taken-branch flushes
   assign cnt_inc[0] = reset & ~pc_write;
   assign cnt_inc[1] = reset & ~freeze & taken_branch;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] count_reg;

         // Saturating performance counter
         always_ff @(posedge clk) begin
            if (!reset) begin
               count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
               count_reg <= count_reg + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign stall_cnt   = g_cnt[0].count_reg;
   assign flush_cnt   = g_cnt[1].count_reg;
   assign err_timeout = err_timeout_reg;

endmodule
